// File: rtl/elevator_pkg.sv
// Shared floor encoding and car state types for the elevator control path.
package elevator_pkg;

    typedef logic [2:0] floor_t;

    localparam floor_t FLOOR_1   = 3'd0;
    localparam floor_t FLOOR_2   = 3'd1;
    localparam floor_t FLOOR_2M  = 3'd2;
    localparam floor_t FLOOR_3   = 3'd3;
    localparam floor_t FLOOR_3M  = 3'd4;
    localparam floor_t FLOOR_4   = 3'd5;
    localparam floor_t FLOOR_TOP = 3'd6;
    localparam floor_t NO_FLOOR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } car_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by travel and door timing.
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Car motion and door controller: steps one floor per travel interval,
// opens the door on arrival and holds it for a timed interval.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sel,
    input  logic       door_hold,
    output logic [2:0] current,
    output logic       door_open,
    output logic       moving_up,
    output logic       moving_down,
    output logic       arrived
);

    localparam int TW = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

    car_state_t    state_q, state_d;
    floor_t        current_q, current_d;
    logic          arrived_q, arrived_d;
    logic          t_load;
    logic [TW-1:0] t_value;
    logic          t_dec;
    logic          t_zero;
    floor_t        next_up;
    floor_t        next_dn;

    cycle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (t_load),
        .load_value (t_value),
        .dec        (t_dec),
        .zero       (t_zero)
    );

    assign next_up = current_q + 3'd1;
    assign next_dn = current_q - 3'd1;

    always_comb begin
        state_d   = state_q;
        current_d = current_q;
        arrived_d = 1'b0;
        t_load    = 1'b0;
        t_value   = '0;
        t_dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel == NO_FLOOR) begin
                    state_d = IDLE;
                end else if (sel == current_q) begin
                    state_d   = DOOR_OPEN;
                    t_load    = 1'b1;
                    t_value   = DOOR_LOAD;
                    arrived_d = 1'b1;
                end else if (sel > current_q) begin
                    state_d = MOVE_UP;
                    t_load  = 1'b1;
                    t_value = TRAVEL_LOAD;
                end else begin
                    state_d = MOVE_DOWN;
                    t_load  = 1'b1;
                    t_value = TRAVEL_LOAD;
                end
            end
            MOVE_UP: begin
                if (current_q == FLOOR_TOP) begin
                    state_d = IDLE;
                end else if (!t_zero) begin
                    t_dec = 1'b1;
                end else begin
                    current_d = next_up;
                    if (sel == next_up) begin
                        state_d   = DOOR_OPEN;
                        t_load    = 1'b1;
                        t_value   = DOOR_LOAD;
                        arrived_d = 1'b1;
                    end else if (sel != NO_FLOOR && sel > next_up) begin
                        t_load  = 1'b1;
                        t_value = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (current_q == FLOOR_1) begin
                    state_d = IDLE;
                end else if (!t_zero) begin
                    t_dec = 1'b1;
                end else begin
                    current_d = next_dn;
                    if (sel == next_dn) begin
                        state_d   = DOOR_OPEN;
                        t_load    = 1'b1;
                        t_value   = DOOR_LOAD;
                        arrived_d = 1'b1;
                    end else if (sel != NO_FLOOR && sel < next_dn) begin
                        t_load  = 1'b1;
                        t_value = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // sel is deliberately ignored while the door is open
                if (door_hold) begin
                    t_load  = 1'b1;
                    t_value = DOOR_LOAD;
                end else if (!t_zero) begin
                    t_dec = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            current_q <= FLOOR_1;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            current_q <= current_d;
            arrived_q <= arrived_d;
        end
    end

    assign current     = current_q;
    assign door_open   = (state_q == DOOR_OPEN);
    assign moving_up   = (state_q == MOVE_UP);
    assign moving_down = (state_q == MOVE_DOWN);
    assign arrived     = arrived_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Randomized bench for elevator_car_ctrl against a trip-level reference model.
module tb_elevator_car_ctrl;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DN   = 2;
    localparam int M_DOOR = 3;

    logic       clk;
    logic       reset;
    logic [2:0] sel;
    logic       door_hold;
    logic [2:0] current;
    logic       door_open;
    logic       moving_up;
    logic       moving_down;
    logic       arrived;

    int total;
    int bad;

    int m_floor;
    int m_mode;
    int m_left;
    int m_arr;

    elevator_car_ctrl #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .door_hold   (door_hold),
        .current     (current),
        .door_open   (door_open),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .arrived     (arrived)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_floor = 0;
        m_mode  = M_IDLE;
        m_left  = 0;
        m_arr   = 0;
    endtask

    task automatic m_open();
        m_mode = M_DOOR;
        m_left = DOOR;
        m_arr  = 1;
    endtask

    // Cycles remaining in the current interval, counted down to 0.
    task automatic m_step(input int s, input bit hold);
        int dir;
        m_arr = 0;
        case (m_mode)
            M_IDLE: begin
                if (s != 7) begin
                    if (s == m_floor) begin
                        m_open();
                    end else begin
                        m_mode = (s > m_floor) ? M_UP : M_DN;
                        m_left = TRAVEL;
                    end
                end
            end
            M_UP, M_DN: begin
                dir = (m_mode == M_UP) ? 1 : -1;
                if ((dir > 0 && m_floor == 6) || (dir < 0 && m_floor == 0)) begin
                    m_mode = M_IDLE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_floor += dir;
                        if (s == m_floor) begin
                            m_open();
                        end else if (s != 7 && (s - m_floor) * dir > 0) begin
                            m_left = TRAVEL;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
            default: begin
                if (hold) begin
                    m_left = DOOR;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("current", int'(current), m_floor);
        chk("door_open", int'(door_open), int'(m_mode == M_DOOR));
        chk("moving_up", int'(moving_up), int'(m_mode == M_UP));
        chk("moving_down", int'(moving_down), int'(m_mode == M_DN));
        chk("arrived", int'(arrived), m_arr);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) m_reset();
        else m_step(int'(sel), door_hold);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    int arr_cnt;

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        sel       = 3'b111;
        door_hold = 1'b0;
        m_reset();
        #2;
        check_all();
        tick();
        reset = 1'b0;

        // idle with no request
        arr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            arr_cnt += int'(arrived);
        end
        chk("idle_arrivals", arr_cnt, 0);

        // 0 -> 3: arrival exactly 12 cycles after the move starts
        sel = 3'd3;
        tick();
        chk("up_started", int'(moving_up), 1);
        for (int i = 0; i < 12; i++) tick();
        chk("up_floor3", int'(current), 3);
        chk("up_arrived", int'(arrived), 1);
        chk("up_door", int'(door_open), 1);
        sel = 3'b111;
        for (int i = 0; i < 3; i++) tick();
        chk("door_closed", int'(door_open), 0);

        // door hold at floor 3 while sel wanders to 6
        sel = 3'd3;
        tick();
        door_hold = 1'b1;
        sel = 3'd6;
        for (int i = 0; i < 5; i++) tick();
        door_hold = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("held_door", int'(moving_up), 0);
        tick();
        chk("after_hold_up", int'(moving_up), 1);
        sel = 3'b111;
        for (int i = 0; i < 20; i++) tick();

        // asynchronous reset mid-move at floor 2
        do_reset();
        sel = 3'd6;
        for (int i = 0; i < 10; i++) tick();
        chk("pre_reset_floor", int'(current), 2);
        #3;
        reset = 1'b1;
        m_reset();
        #1;
        chk("async_current", int'(current), 0);
        chk("async_up", int'(moving_up), 0);
        tick();
        reset = 1'b0;
        sel = 3'b111;
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) sel = 3'($urandom_range(0, 7));
            door_hold = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 499) == 0);
            if (reset) m_reset();
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
